// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit registers: PPC-writable control registers
// with one-cycle update strobes, or user-driven status registers readable from the PPC.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]              C_BASEADDR   = 32'h01004700,
  parameter logic [31:0]              C_HIGHADDR   = 32'h010047FF,
  parameter int                       C_OPB_AWIDTH = 32,
  parameter int                       C_OPB_DWIDTH = 32,
  parameter int                       C_NUM_REGS   = 8,
  parameter logic [C_NUM_REGS-1:0]    C_RO_MASK    = '0,
  parameter logic [C_NUM_REGS*32-1:0] C_RST_VAL    = '0,
  parameter                           C_FAMILY     = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  input  logic [C_NUM_REGS*32-1:0]   user_data_in,
  output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

  localparam int IDX_W = C_OPB_AWIDTH - 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [C_OPB_AWIDTH-1:0]   addr, offset;
  logic [IDX_W-1:0]          idx;
  logic [31:0]               wdata;
  logic [3:0]                be;
  logic                      hit, go, idx_in_range;
  logic [31:0]               rdata_d, rdata_q;
  logic [C_NUM_REGS-1:0]     strobe_d, strobe_q;
  logic                      unused_ok;

  // Big-endian bus vectors land MSB-first, so be[3] is OPB_BE[0] and covers bits [31:24].
  assign addr         = OPB_ABus;
  assign wdata        = OPB_DBus;
  assign be           = OPB_BE;
  assign offset       = addr - C_BASEADDR;
  assign idx          = offset[C_OPB_AWIDTH-1:2];
  assign idx_in_range = (idx < IDX_W'(C_NUM_REGS));
  assign hit          = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // A transfer is accepted only from IDLE, which blocks back-to-back acks on a held select.
  assign go           = hit && (state_q == S_IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
    if (!OPB_Rst_n) begin
      state_q  <= S_IDLE;
      rdata_q  <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
    end
  end

  // Strobe fires for any accepted write to a writable in-range slot, even with BE=0000.
  always_comb begin
    strobe_d = '0;
    if (go && !OPB_RNW && idx_in_range) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (!C_RO_MASK[i] && (idx == IDX_W'(i))) strobe_d[i] = 1'b1;
      end
    end
  end

  // Read data is zero outside the ack cycle so the OR'd OPB data bus stays clean.
  always_comb begin
    rdata_d = '0;
    if (go && OPB_RNW && idx_in_range) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) begin
          rdata_d = C_RO_MASK[i] ? user_data_in[32*i +: 32] : user_data_out[32*i +: 32];
        end
      end
    end
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
    if (C_RO_MASK[i]) begin : g_ro
      assign user_data_out[32*i +: 32] = '0;
    end else begin : g_rw
      logic [31:0] reg_q;
      logic        wr_en;

      assign wr_en = go && !OPB_RNW && idx_in_range && (idx == IDX_W'(i));

      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        // NOTE: each register is an individual flop with its own reset value, not a RAM, so resetting it is free.
        if (!OPB_Rst_n) begin
          reg_q <= C_RST_VAL[32*i +: 32];
        end else if (wr_en) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) reg_q[8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end

      assign user_data_out[32*i +: 32] = reg_q;
    end
  end

  assign Sl_xferAck     = (state_q == S_ACK);
  assign Sl_DBus        = rdata_q;
  assign user_wr_strobe = strobe_q;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

  assign unused_ok = ^{1'b0, OPB_seqAddr, offset[1:0], C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: 4 registers, reg1 reset to DEADBEEF, reg3 read-only.
module tb_opb_register_bank_ppc2simulink;

  localparam int NREGS = 4;

  logic              clk;
  logic              rst_n;
  logic [0:31]       OPB_ABus;
  logic [0:3]        OPB_BE;
  logic [0:31]       OPB_DBus;
  logic              OPB_RNW;
  logic              OPB_select;
  logic              OPB_seqAddr;
  logic [0:31]       Sl_DBus;
  logic              Sl_xferAck;
  logic              Sl_errAck;
  logic              Sl_retry;
  logic              Sl_toutSup;
  logic [NREGS*32-1:0] user_data_out;
  logic [NREGS*32-1:0] user_data_in;
  logic [NREGS-1:0]  user_wr_strobe;

  int checks = 0;
  int errors = 0;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (32'h01004700),
    .C_HIGHADDR  (32'h010047FF),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_NUM_REGS  (NREGS),
    .C_RO_MASK   (4'b1000),
    .C_RST_VAL   ({32'h0, 32'h0, 32'hDEADBEEF, 32'h0}),
    .C_FAMILY    ("virtex5")
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst_n     (rst_n),
    .OPB_ABus      (OPB_ABus),
    .OPB_BE        (OPB_BE),
    .OPB_DBus      (OPB_DBus),
    .OPB_RNW       (OPB_RNW),
    .OPB_select    (OPB_select),
    .OPB_seqAddr   (OPB_seqAddr),
    .Sl_DBus       (Sl_DBus),
    .Sl_xferAck    (Sl_xferAck),
    .Sl_errAck     (Sl_errAck),
    .Sl_retry      (Sl_retry),
    .Sl_toutSup    (Sl_toutSup),
    .user_data_out (user_data_out),
    .user_data_in  (user_data_in),
    .user_wr_strobe(user_wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rnw;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic         exp_ack;
    logic [31:0]  exp_rdata;
    logic [3:0]   exp_strobe;
    logic [127:0] exp_udo;
  } vec_t;

  vec_t sb_q[$];

  function automatic logic [127:0] udo(input logic [31:0] r3, r2, r1, r0);
    return {r3, r2, r1, r0};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bus_idle();
    OPB_select = 1'b0;
    OPB_RNW    = 1'b1;
    OPB_ABus   = '0;
    OPB_BE     = '0;
    OPB_DBus   = '0;
  endtask

  // Drive one transfer, hold select until ack (or 16 cycles), then score against the queue.
  task automatic run_xfer(input vec_t v);
    vec_t         e;
    logic         got_ack;
    int           ack_cyc;
    logic [31:0]  rd;
    logic [3:0]   stb;
    logic [127:0] udo_got;
    logic         leak;
    @(negedge clk);
    OPB_ABus   = v.addr;
    OPB_BE     = v.be;
    OPB_DBus   = v.wdata;
    OPB_RNW    = v.rnw;
    OPB_select = 1'b1;
    sb_q.push_back(v);
    got_ack = 1'b0; ack_cyc = 0; rd = '0; stb = '0; leak = 1'b0;
    for (int c = 1; c <= 16 && !got_ack; c++) begin
      @(posedge clk); #1;
      if (Sl_xferAck) begin
        got_ack = 1'b1;
        ack_cyc = c;
        rd      = Sl_DBus;
        stb     = user_wr_strobe;
      end else if (Sl_DBus != 0 || user_wr_strobe != 0) begin
        leak = 1'b1;
      end
    end
    udo_got = user_data_out;
    @(negedge clk);
    bus_idle();
    e = sb_q.pop_front();
    check({e.name, " ack"}, got_ack, e.exp_ack);
    check({e.name, " quiet before ack"}, leak, 1'b0);
    check({e.name, " user_data_out"}, udo_got, e.exp_udo);
    if (e.exp_ack) begin
      check({e.name, " ack cycle"}, ack_cyc, 1);
      check({e.name, " rdata"}, rd, e.exp_rdata);
      check({e.name, " strobe"}, stb, e.exp_strobe);
    end
    @(posedge clk); #1;
    check({e.name, " after ack {ack,dbus,strobe}"}, {Sl_xferAck, Sl_DBus, user_wr_strobe}, 37'h0);
  endtask

  vec_t vecs[12];

  initial begin
    OPB_seqAddr  = 1'b0;
    user_data_in = {32'hCAFEF00D, 32'hBAD00002, 32'hBAD00001, 32'hBAD00000};
    bus_idle();
    rst_n = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset user_data_out", user_data_out, udo(32'h0, 32'h0, 32'hDEADBEEF, 32'h0));
    check("reset ack", Sl_xferAck, 1'b0);
    check("reset strobe", user_wr_strobe, 4'b0000);
    check("reset dbus", Sl_DBus, 32'h0);
    check("tied outputs", {Sl_errAck, Sl_retry, Sl_toutSup}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ---- held select: one ack only, one-cycle strobe ----
    @(negedge clk);
    OPB_ABus = 32'h01004708; OPB_BE = 4'b1111; OPB_DBus = 32'h12345678;
    OPB_RNW = 1'b0; OPB_select = 1'b1;
    @(posedge clk); #1;
    check("held: ack in cycle 2", Sl_xferAck, 1'b1);
    check("held: strobe", user_wr_strobe, 4'b0100);
    check("held: reg2 in ack cycle", user_data_out[95:64], 32'h12345678);
    @(posedge clk); #1;
    check("held: no back-to-back ack", Sl_xferAck, 1'b0);
    check("held: strobe one cycle", user_wr_strobe, 4'b0000);
    @(negedge clk);
    bus_idle();
    @(posedge clk); #1;
    check("held: idle after drop", Sl_xferAck, 1'b0);

    // ---- table-driven transfers ----
    vecs[0]  = '{"wr reg2 BE0101", 1'b0, 32'h01004708, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h0, 4'b0100,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[1]  = '{"rd reg2", 1'b1, 32'h01004708, 4'b1111, 32'h0, 1'b1, 32'h12BB56DD, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[2]  = '{"wr ro reg3", 1'b0, 32'h0100470C, 4'b1111, 32'h0, 1'b1, 32'h0, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[3]  = '{"rd ro reg3", 1'b1, 32'h0100470C, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[4]  = '{"rd idx4", 1'b1, 32'h01004710, 4'b1111, 32'h0, 1'b1, 32'h0, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[5]  = '{"rd out of window", 1'b1, 32'h01004800, 4'b1111, 32'h0, 1'b0, 32'h0, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[6]  = '{"wr reg1 BE0000", 1'b0, 32'h01004704, 4'b0000, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0010,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[7]  = '{"rd reg1 low bits set", 1'b1, 32'h01004707, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0)};
    vecs[8]  = '{"wr reg0 BE1000", 1'b0, 32'h01004700, 4'b1000, 32'h0F0F0F0F, 1'b1, 32'h0, 4'b0001,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0F000000)};
    vecs[9]  = '{"rd reg0", 1'b1, 32'h01004700, 4'b1111, 32'h0, 1'b1, 32'h0F000000, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0F000000)};
    vecs[10] = '{"wr idx5", 1'b0, 32'h01004714, 4'b1111, 32'h00000001, 1'b1, 32'h0, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0F000000)};
    vecs[11] = '{"rd below base", 1'b1, 32'h010046FC, 4'b1111, 32'h0, 1'b0, 32'h0, 4'b0000,
                 udo(32'h0, 32'h12BB56DD, 32'hDEADBEEF, 32'h0F000000)};
    for (int i = 0; i < 12; i++) run_xfer(vecs[i]);

    // ---- reset pulse in the ack cycle of a write to reg0 ----
    @(negedge clk);
    OPB_ABus = 32'h01004700; OPB_BE = 4'b1111; OPB_DBus = 32'h11111111;
    OPB_RNW = 1'b0; OPB_select = 1'b1;
    @(posedge clk); #1;
    check("rst-mid: ack before reset", Sl_xferAck, 1'b1);
    check("rst-mid: reg0 written", user_data_out[31:0], 32'h11111111);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst-mid: {ack,strobe} drop", {Sl_xferAck, user_wr_strobe}, 5'b0);
    check("rst-mid: regs at reset value", user_data_out, udo(32'h0, 32'h0, 32'hDEADBEEF, 32'h0));
    @(negedge clk);
    bus_idle();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst-mid: no late ack", Sl_xferAck, 1'b0);
    run_xfer('{"post-reset rd reg1", 1'b1, 32'h01004704, 4'b1111, 32'h0, 1'b1, 32'hDEADBEEF, 4'b0000,
               udo(32'h0, 32'h0, 32'hDEADBEEF, 32'h0)});
    run_xfer('{"post-reset wr reg2", 1'b0, 32'h01004708, 4'b0011, 32'h0000BEEF, 1'b1, 32'h0, 4'b0100,
               udo(32'h0, 32'h0000BEEF, 32'hDEADBEEF, 32'h0)});

    check("scoreboard drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
